i2c_master_burst: RTL and testbench

//  Parametrised I2C master: START, 7-bit address + R/W, N-byte burst read or write, STOP.

---
 rtl/i2c_master_burst.sv | 265 ++++++++++++++++++++++++++
 tb/tb_i2c_master_burst.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_burst.sv
// I2C master: START, 7-bit address + R/W, N-byte burst read or write, STOP, with ACK/NACK sensing.
// Define I2C_CLK_STRETCH_EN to let a slave hold SCL low and stall the high phase of a bit slot.
module i2c_master_burst #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CNT_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             rw,
  input  logic [6:0]       slave_addr,
  input  logic [CNT_W-1:0] nbytes,
  input  logic [7:0]       wr_data,
  output logic             wr_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic             nack,
  output logic [2:0]       state,
  output logic             scl,
  output logic             sda_out,
  input  logic             sda_in,
  input  logic             scl_in
);

  localparam int unsigned DivW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StAddr  = 3'd2,
    StAack  = 3'd3,
    StWrite = 3'd4,
    StRead  = 3'd5,
    StDack  = 3'd6,
    StStop  = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [1:0]       phase_q, phase_d;
  logic [2:0]       bit_q, bit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic [6:0]       addr_q, addr_d;
  logic             rw_q, rw_d;
  logic             samp_q, samp_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             nack_q, nack_d;
  logic             wr_ready_q, wr_ready_d;
  logic             rd_valid_q, rd_valid_d;
  logic             scl_q, scl_d;
  logic             sda_q, sda_d;

  logic tick, hold, adv, slot_end, sample, more_bytes;

`ifdef I2C_CLK_STRETCH_EN
  // Only a stretch once we have released SCL counts; the output flop lags the phase by a clock.
  assign hold = (phase_q == 2'd2) && scl_q && !scl_in;
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign hold          = 1'b0;
`endif

  assign tick       = (div_q == DivW'(CLK_DIV - 1));
  assign adv        = tick && !hold;
  assign slot_end   = adv && (phase_q == 2'd3);
  assign sample     = adv && (phase_q == 2'd1);
  assign more_bytes = (cnt_q > CNT_W'(1));

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    phase_d    = phase_q;
    bit_d      = bit_q;
    cnt_d      = cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rd_data_d  = rd_data_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    samp_d     = samp_q;
    busy_d     = busy_q;
    nack_d     = nack_q;
    done_d     = 1'b0;
    wr_ready_d = 1'b0;
    rd_valid_d = 1'b0;

    if (state_q == StIdle) begin
      div_d   = '0;
      phase_d = 2'd0;
      if (start) begin
        addr_d  = slave_addr;
        rw_d    = rw;
        cnt_d   = (nbytes == '0) ? CNT_W'(1) : nbytes;
        busy_d  = 1'b1;
        nack_d  = 1'b0;
        state_d = StStart;
      end
    end else if (!hold) begin
      div_d = tick ? '0 : div_q + DivW'(1);
      if (tick) phase_d = phase_q + 2'd1;
    end

    if (sample) begin
      samp_d = sda_in;
      if (state_q == StRead) begin
        rx_d = {rx_q[6:0], sda_in};
        if (bit_q == 3'd7) begin
          rd_data_d  = {rx_q[6:0], sda_in};
          rd_valid_d = 1'b1;
        end
      end
    end

    if (slot_end) begin
      unique case (state_q)
        StStart: begin
          state_d = StAddr;
          bit_d   = 3'd0;
          tx_d    = {addr_q, rw_q};
        end
        StAddr: begin
          if (bit_q == 3'd7) state_d = StAack;
          else bit_d = bit_q + 3'd1;
        end
        StAack: begin
          bit_d = 3'd0;
          if (samp_q) begin
            nack_d  = 1'b1;
            state_d = StStop;
          end else if (rw_q) begin
            state_d = StRead;
          end else begin
            state_d    = StWrite;
            tx_d       = wr_data;
            wr_ready_d = 1'b1;
          end
        end
        StWrite, StRead: begin
          if (bit_q == 3'd7) state_d = StDack;
          else bit_d = bit_q + 3'd1;
        end
        StDack: begin
          bit_d = 3'd0;
          if (!rw_q && samp_q) begin
            nack_d  = 1'b1;
            state_d = StStop;
          end else if (more_bytes) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (rw_q) begin
              state_d = StRead;
            end else begin
              state_d    = StWrite;
              tx_d       = wr_data;
              wr_ready_d = 1'b1;
            end
          end else begin
            state_d = StStop;
          end
        end
        StStop: begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Line levels are decoded from the current slot/phase and registered so the pads never glitch.
  always_comb begin
    scl_d = 1'b1;
    sda_d = 1'b1;
    unique case (state_q)
      StIdle: begin
        scl_d = 1'b1;
        sda_d = 1'b1;
      end
      StStart: begin
        scl_d = (phase_q != 2'd3);
        sda_d = (phase_q == 2'd0);
      end
      StAddr, StWrite: begin
        scl_d = phase_q[1];
        sda_d = tx_q[3'd7 - bit_q];
      end
      StAack, StRead: begin
        scl_d = phase_q[1];
        sda_d = 1'b1;
      end
      StDack: begin
        scl_d = phase_q[1];
        sda_d = rw_q ? !more_bytes : 1'b1;
      end
      StStop: begin
        scl_d = (phase_q != 2'd0);
        sda_d = (phase_q == 2'd3);
      end
      default: begin
        scl_d = 1'b1;
        sda_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      div_q      <= '0;
      phase_q    <= 2'd0;
      bit_q      <= 3'd0;
      cnt_q      <= '0;
      tx_q       <= 8'h00;
      rx_q       <= 8'h00;
      rd_data_q  <= 8'h00;
      addr_q     <= 7'h00;
      rw_q       <= 1'b0;
      samp_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      nack_q     <= 1'b0;
      wr_ready_q <= 1'b0;
      rd_valid_q <= 1'b0;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      cnt_q      <= cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rd_data_q  <= rd_data_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      samp_q     <= samp_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      nack_q     <= nack_d;
      wr_ready_q <= wr_ready_d;
      rd_valid_q <= rd_valid_d;
      scl_q      <= scl_d;
      sda_q      <= sda_d;
    end
  end

  assign wr_ready = wr_ready_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign nack     = nack_q;
  assign state    = state_q;
  assign scl      = scl_q;
  assign sda_out  = sda_q;

endmodule

// File: tb/tb_i2c_master_burst.sv
// Bench for i2c_master_burst: a bus-level slave model checks captured bytes against a scoreboard,
// plus latency, status and reset checks.
module tb_i2c_master_burst;

  localparam int unsigned ClkDiv = 4;
  localparam int unsigned Slot   = 4 * ClkDiv;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] slave_addr = 7'h00;
  logic [2:0] nbytes = 3'd0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready, rd_valid, busy, done, nack, scl, sda_out, sda_in, scl_in;
  logic [7:0] rd_data;
  logic [2:0] state;

  logic sda_slv = 1'b1;
  logic stretch = 1'b0;
  logic ack_en  = 1'b1;

  assign sda_in = sda_out & sda_slv;
  assign scl_in = scl & ~stretch;

  i2c_master_burst #(.CLK_DIV(ClkDiv), .CNT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rw         (rw),
    .slave_addr (slave_addr),
    .nbytes     (nbytes),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .busy       (busy),
    .done       (done),
    .nack       (nack),
    .state      (state),
    .scl        (scl),
    .sda_out    (sda_out),
    .sda_in     (sda_in),
    .scl_in     (scl_in)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] exp_byte_q[$];  // bytes the slave must see on the bus
  logic [7:0] exp_rd_q[$];    // bytes rd_data must present
  logic       exp_mack_q[$];  // master ACK(0)/NACK(1) after each read byte
  logic [7:0] slv_tx_q[$];    // bytes the slave returns
  logic [7:0] wr_src_q[$];    // bytes offered on wr_data

  int wr_ready_cnt = 0;
  int rd_valid_cnt = 0;
  int done_cnt     = 0;

  // Slave model and output monitors.
  initial begin
    int         cnt  = 0;
    int         mode = 0;  // 0 idle, 1 address, 2 write data, 3 read data
    logic [7:0] sh   = 8'h00;
    logic [7:0] tx   = 8'hFF;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic       scl_n, sda_n;
    forever begin
      @(negedge clk);
      scl_n = scl;
      sda_n = sda_out & sda_slv;
      if (!rst) begin
        mode    = 0;
        sda_slv = 1'b1;
      end else begin
        if (wr_ready) begin
          wr_ready_cnt++;
          if (wr_src_q.size() > 0) void'(wr_src_q.pop_front());
          if (wr_src_q.size() > 0) wr_data = wr_src_q[0];
        end
        if (rd_valid) begin
          rd_valid_cnt++;
          if (exp_rd_q.size() > 0) check_val("rd_data", {24'h0, rd_data}, {24'h0, exp_rd_q.pop_front()});
          else check_val("rd_valid_unexpected", 32'd1, 32'd0);
        end
        if (done) done_cnt++;
        if (prev_scl && scl_n && prev_sda && !sda_n) begin
          mode = 1;
          cnt  = 0;
        end else if (prev_scl && scl_n && !prev_sda && sda_n) begin
          mode    = 0;
          sda_slv = 1'b1;
        end else if (!prev_scl && scl_n && mode != 0) begin
          if (cnt < 8) begin
            sh = {sh[6:0], sda_n};
            cnt++;
          end else begin
            cnt = 0;
            if (mode == 3) begin
              if (exp_mack_q.size() > 0) check_val("master_ack", {31'h0, sda_n}, {31'h0, exp_mack_q.pop_front()});
              else check_val("master_ack_unexpected", 32'd1, 32'd0);
              if (sda_n) mode = 0;
              else tx = (slv_tx_q.size() > 0) ? slv_tx_q.pop_front() : 8'hFF;
            end else begin
              if (exp_byte_q.size() > 0) check_val("bus_byte", {24'h0, sh}, {24'h0, exp_byte_q.pop_front()});
              else check_val("bus_byte_unexpected", {24'h0, sh}, 32'h100);
              if (mode == 1) begin
                if (!ack_en) mode = 0;
                else if (sh[0]) begin
                  mode = 3;
                  tx   = (slv_tx_q.size() > 0) ? slv_tx_q.pop_front() : 8'hFF;
                end else mode = 2;
              end
            end
          end
        end else if (prev_scl && !scl_n) begin
          if (mode == 0) sda_slv = 1'b1;
          else if (cnt == 8) sda_slv = (mode == 3) ? 1'b1 : !ack_en;
          else sda_slv = (mode == 3) ? tx[7 - cnt] : 1'b1;
        end
      end
      prev_scl = scl_n;
      prev_sda = sda_n;
    end
  end

  task automatic add_addr(input logic [6:0] a, input logic r);
    exp_byte_q.push_back({a, r});
  endtask

  task automatic add_wr(input logic [7:0] d);
    exp_byte_q.push_back(d);
    wr_src_q.push_back(d);
  endtask

  task automatic add_rd(input logic [7:0] d, input logic last);
    slv_tx_q.push_back(d);
    exp_rd_q.push_back(d);
    exp_mack_q.push_back(last);
  endtask

  task automatic run_txn(input string tag, input logic rw_i, input logic [6:0] addr_i,
                         input logic [2:0] n_i, input logic ack_i, input int exp_lat,
                         input logic exp_nack, input int exp_wr, input int exp_rd,
                         input logic do_stretch);
    int   m       = 0;
    int   rises   = 0;
    int   left    = 0;
    logic prev    = 1'b1;
    ack_en       = ack_i;
    wr_ready_cnt = 0;
    rd_valid_cnt = 0;
    done_cnt     = 0;
    if (wr_src_q.size() > 0) wr_data = wr_src_q[0];
    @(negedge clk);
    rw         = rw_i;
    slave_addr = addr_i;
    nbytes     = n_i;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val({tag, "_busy_on_accept"}, {31'h0, busy}, 32'd1);
    check_val({tag, "_nack_clr_on_accept"}, {31'h0, nack}, 32'd0);
    while (!done && m < 5000) begin
      @(negedge clk);
      m++;
      if (m == 100) start = 1'b1;
      else if (m == 101) start = 1'b0;
      if (left > 0) begin
        left--;
        if (left == 0) stretch = 1'b0;
      end
      if (!prev && scl) begin
        rises++;
        if (do_stretch && rises == 7) begin
          stretch = 1'b1;
          left    = 50;
        end
      end
      prev = scl;
    end
    start   = 1'b0;
    stretch = 1'b0;
    check_val({tag, "_latency"}, m, exp_lat);
    check_val({tag, "_nack"}, {31'h0, nack}, {31'h0, exp_nack});
    check_val({tag, "_busy_at_done"}, {31'h0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    check_val({tag, "_idle_after"}, {29'h0, state}, 32'd0);
    check_val({tag, "_done_count"}, done_cnt, 32'd1);
    check_val({tag, "_wr_ready_count"}, wr_ready_cnt, exp_wr);
    check_val({tag, "_rd_valid_count"}, rd_valid_cnt, exp_rd);
    check_val({tag, "_queues_drained"}, exp_byte_q.size() + exp_rd_q.size() + exp_mack_q.size(), 32'd0);
  endtask

  function automatic int lat(input int n);
    return (11 + 9 * n) * Slot;
  endfunction

  initial begin
    int         m;
    int         stretch_extra;
    logic [7:0] r;
`ifdef I2C_CLK_STRETCH_EN
    stretch_extra = 50;
`else
    stretch_extra = 0;
`endif
    repeat (3) @(negedge clk);
    check_val("rst_scl", {31'h0, scl}, 32'd1);
    check_val("rst_sda", {31'h0, sda_out}, 32'd1);
    check_val("rst_status", {27'h0, busy, done, nack, rd_valid, wr_ready}, 32'd0);
    check_val("rst_rd_data", {24'h0, rd_data}, 32'd0);
    check_val("rst_state", {29'h0, state}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    add_addr(7'h50, 1'b0);
    add_wr(8'hA6);
    run_txn("wr1", 1'b0, 7'h50, 3'd1, 1'b1, lat(1), 1'b0, 1, 0, 1'b0);

    add_addr(7'h3C, 1'b1);
    add_rd(8'hF6, 1'b0);
    add_rd(8'h5A, 1'b1);
    run_txn("rd2", 1'b1, 7'h3C, 3'd2, 1'b1, lat(2), 1'b0, 0, 2, 1'b0);

    add_addr(7'h21, 1'b0);
    wr_src_q.push_back(8'h99);
    run_txn("addr_nack", 1'b0, 7'h21, 3'd2, 1'b0, 11 * Slot, 1'b1, 0, 0, 1'b0);
    wr_src_q.delete();

    add_addr(7'h33, 1'b0);
    add_wr(8'h81);
    run_txn("n0", 1'b0, 7'h33, 3'd0, 1'b1, lat(1), 1'b0, 1, 0, 1'b0);

    add_addr(7'h7F, 1'b0);
    add_wr(8'h00);
    add_wr(8'hFF);
    add_wr(8'h5C);
    run_txn("wr3", 1'b0, 7'h7F, 3'd3, 1'b1, lat(3), 1'b0, 3, 0, 1'b0);

    add_addr(7'h0A, 1'b1);
    for (int i = 0; i < 3; i++) begin
      r = 8'($urandom_range(0, 255));
      add_rd(r, i == 2);
    end
    run_txn("rd3", 1'b1, 7'h0A, 3'd3, 1'b1, lat(3), 1'b0, 0, 3, 1'b0);

    // Reset in the middle of a write burst.
    add_addr(7'h12, 1'b0);
    add_wr(8'hC3);
    add_wr(8'h3C);
    add_wr(8'h77);
    ack_en       = 1'b1;
    wr_ready_cnt = 0;
    done_cnt     = 0;
    wr_data      = wr_src_q[0];
    @(negedge clk);
    rw         = 1'b0;
    slave_addr = 7'h12;
    nbytes     = 3'd3;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m     = 0;
    while (wr_ready_cnt == 0 && m < 2000) begin
      @(negedge clk);
      m++;
    end
    check_val("mid_wr_ready_seen", {31'h0, wr_ready_cnt == 1}, 32'd1);
    repeat (3 * Slot + Slot / 2) @(negedge clk);
    check_val("mid_state_write", {29'h0, state}, 32'd4);
    rst = 1'b0;
    @(negedge clk);
    check_val("mid_rst_scl", {31'h0, scl}, 32'd1);
    check_val("mid_rst_sda", {31'h0, sda_out}, 32'd1);
    check_val("mid_rst_busy", {31'h0, busy}, 32'd0);
    check_val("mid_rst_state", {29'h0, state}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    exp_byte_q.delete();
    wr_src_q.delete();
    repeat (4) @(negedge clk);
    check_val("mid_no_done", done_cnt, 32'd0);

    add_addr(7'h45, 1'b0);
    add_wr(8'h1E);
    add_wr(8'hE1);
    run_txn("post_rst", 1'b0, 7'h45, 3'd2, 1'b1, lat(2), 1'b0, 2, 0, 1'b0);

    add_addr(7'h50, 1'b0);
    add_wr(8'hA6);
    run_txn("stretch", 1'b0, 7'h50, 3'd1, 1'b1, lat(1) + stretch_extra, 1'b0, 1, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
